// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with per-digit trigger addend, synchronous load,
// wrap/saturate overflow handling and one-cycle overflow/underflow/load-error pulses.
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic [DIGITS-1:0]     Trigger,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadData,
    output logic [4*DIGITS-1:0]   DataOut,
    output logic                  Overflow,
    output logic                  Underflow,
    output logic                  LoadError
);

    logic [4*DIGITS-1:0] r_data;
    logic                r_ovf;
    logic                r_unf;
    logic                r_lerr;

    logic [4*DIGITS-1:0] w_cnt;
    logic [4*DIGITS-1:0] w_ld;
    logic                w_c;
    logic                w_bad;
    logic [4:0]          w_s;
    logic [3:0]          w_nib;
    logic                w_count;

    assign w_count = Enable && (|Trigger);

    always_comb begin
        w_cnt = '0;
        w_ld  = '0;
        w_c   = 1'b0;
        w_bad = 1'b0;
        w_s   = '0;
        w_nib = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            // w_c is the carry when adding, the borrow when subtracting
            if (Up) begin
                w_s = {1'b0, r_data[4*k +: 4]} + {4'b0, Trigger[k]} + {4'b0, w_c};
                if (w_s > 5'd9) begin
                    w_cnt[4*k +: 4] = 4'(w_s - 5'd10);
                    w_c = 1'b1;
                end else begin
                    w_cnt[4*k +: 4] = w_s[3:0];
                    w_c = 1'b0;
                end
            end else begin
                // negative results appear as two's complement in 5 bits
                w_s = {1'b0, r_data[4*k +: 4]} - {4'b0, Trigger[k]} - {4'b0, w_c};
                if (w_s[4]) begin
                    w_cnt[4*k +: 4] = 4'(w_s + 5'd10);
                    w_c = 1'b1;
                end else begin
                    w_cnt[4*k +: 4] = w_s[3:0];
                    w_c = 1'b0;
                end
            end
            w_nib = LoadData[4*k +: 4];
            if (w_nib > 4'd9) begin
                w_ld[4*k +: 4] = 4'd0;
                w_bad = 1'b1;
            end else begin
                w_ld[4*k +: 4] = w_nib;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_lerr <= 1'b0;
        end else if (Load) begin
            r_data <= w_ld;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_lerr <= w_bad;
        end else if (w_count) begin
            r_lerr <= 1'b0;
            r_ovf  <= w_c && Up;
            r_unf  <= w_c && !Up;
            if (w_c && !WRAP) begin
                r_data <= Up ? {DIGITS{4'h9}} : '0;
            end else begin
                r_data <= w_cnt;
            end
        end else begin
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_lerr <= 1'b0;
        end
    end

    assign DataOut   = r_data;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign LoadError = r_lerr;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 4-digit wrapping and a 2-digit saturating instance,
// checked every cycle against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;

    logic        a_en = 1'b0, a_up = 1'b0, a_ld = 1'b0;
    logic [3:0]  a_trig = '0;
    logic [15:0] a_ldata = '0;
    logic [15:0] a_out;
    logic        a_ovf, a_unf, a_lerr;

    logic        b_en = 1'b0, b_up = 1'b0, b_ld = 1'b0;
    logic [1:0]  b_trig = '0;
    logic [7:0]  b_ldata = '0;
    logic [7:0]  b_out;
    logic        b_ovf, b_unf, b_lerr;

    int total = 0;
    int bad = 0;
    longint ma = 0, mb = 0;
    bit ea_o, ea_u, ea_l, eb_o, eb_u, eb_l;

    always #5 Clk = ~Clk;

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Enable(a_en), .Up(a_up), .Trigger(a_trig),
        .Load(a_ld), .LoadData(a_ldata), .DataOut(a_out),
        .Overflow(a_ovf), .Underflow(a_unf), .LoadError(a_lerr)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Enable(b_en), .Up(b_up), .Trigger(b_trig),
        .Load(b_ld), .LoadData(b_ldata), .DataOut(b_out),
        .Overflow(b_ovf), .Underflow(b_unf), .LoadError(b_lerr)
    );

    function automatic logic [31:0] to_bcd(input longint v, input int digits);
        logic [31:0] r = '0;
        longint x = v;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model(input int digits, input bit wrap, input bit rst, input bit ld,
                         input bit en, input bit up, input logic [31:0] ldata,
                         input logic [7:0] trig, inout longint val,
                         output bit ovf, output bit unf, output bit lerr);
        longint p = 1;
        longint a = 0;
        longint nib;
        ovf = 1'b0; unf = 1'b0; lerr = 1'b0;
        if (rst) begin
            val = 0;
        end else if (ld) begin
            val = 0;
            for (int k = 0; k < digits; k++) begin
                nib = longint'((ldata >> (4*k)) & 32'hF);
                if (nib > 9) lerr = 1'b1;
                else val += nib * p;
                p *= 10;
            end
        end else if (en && trig != 8'h0) begin
            for (int k = 0; k < digits; k++) begin
                if (trig[k]) a += p;
                p *= 10;
            end
            if (up) begin
                val += a;
                if (val >= p) begin
                    ovf = 1'b1;
                    val = wrap ? val - p : p - 1;
                end
            end else begin
                val -= a;
                if (val < 0) begin
                    unf = 1'b1;
                    val = wrap ? val + p : 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("A.data", {16'h0, a_out}, to_bcd(ma, 4));
        chk("A.ovf",  {31'h0, a_ovf},  {31'h0, ea_o});
        chk("A.unf",  {31'h0, a_unf},  {31'h0, ea_u});
        chk("A.lerr", {31'h0, a_lerr}, {31'h0, ea_l});
        chk("B.data", {24'h0, b_out}, to_bcd(mb, 2));
        chk("B.ovf",  {31'h0, b_ovf},  {31'h0, eb_o});
        chk("B.unf",  {31'h0, b_unf},  {31'h0, eb_u});
        chk("B.lerr", {31'h0, b_lerr}, {31'h0, eb_l});
    endtask

    // one clock: inputs stay stable across the edge, then model and DUTs are compared
    task automatic cyc();
        @(posedge Clk);
        #1;
        model(4, 1'b1, Reset, a_ld, a_en, a_up, {16'h0, a_ldata}, {4'h0, a_trig}, ma, ea_o, ea_u, ea_l);
        model(2, 1'b0, Reset, b_ld, b_en, b_up, {24'h0, b_ldata}, {6'h0, b_trig}, mb, eb_o, eb_u, eb_l);
        check_all();
    endtask

    initial begin
        #2;
        ea_o = 0; ea_u = 0; ea_l = 0; eb_o = 0; eb_u = 0; eb_l = 0;
        check_all();
        cyc();
        Reset = 1'b0;

        // count up by 1111 ten times: wraps to 1110 with a single overflow pulse
        a_en = 1'b1; a_up = 1'b1; a_trig = 4'b1111;
        repeat (10) cyc();
        chk("plan.wrap", {16'h0, a_out}, 32'h1110);
        chk("plan.wrap_ovf", {31'h0, a_ovf}, 32'h1);
        a_en = 1'b0;
        cyc();
        chk("plan.ovf_clear", {31'h0, a_ovf}, 32'h0);

        // load 5, subtract 10: borrow out of the top digit
        a_ld = 1'b1; a_ldata = 16'h0005; cyc();
        a_ld = 1'b0; a_en = 1'b1; a_up = 1'b0; a_trig = 4'b0010; cyc();
        chk("plan.unf", {16'h0, a_out}, 32'h9995);

        // carry and borrow ripple across three digits
        a_en = 1'b0; a_ld = 1'b1; a_ldata = 16'h0999; cyc();
        a_ld = 1'b0; a_en = 1'b1; a_up = 1'b1; a_trig = 4'b0001; cyc();
        chk("plan.ripple_up", {16'h0, a_out}, 32'h1000);
        a_up = 1'b0; cyc();
        chk("plan.ripple_dn", {16'h0, a_out}, 32'h0999);

        // invalid nibble loads as 0; load wins over a simultaneous count
        a_en = 1'b0; a_ld = 1'b1; a_ldata = 16'h12F4; cyc();
        chk("plan.lerr_data", {16'h0, a_out}, 32'h1204);
        a_en = 1'b1; a_up = 1'b1; a_trig = 4'b1111; a_ldata = 16'h0321; cyc();
        chk("plan.load_wins", {16'h0, a_out}, 32'h0321);

        // disabled counting holds
        a_ld = 1'b0; a_en = 1'b0;
        repeat (5) cyc();
        chk("plan.hold", {16'h0, a_out}, 32'h0321);

        // asynchronous reset mid-cycle, then resume from 0
        a_en = 1'b1; a_up = 1'b1; a_trig = 4'b1111;
        repeat (2) cyc();
        #2 Reset = 1'b1;
        #1;
        ma = 0; mb = 0; ea_o = 0; ea_u = 0; ea_l = 0; eb_o = 0; eb_u = 0; eb_l = 0;
        check_all();
        #3 Reset = 1'b0;
        cyc();
        chk("plan.resume", {16'h0, a_out}, 32'h1111);
        a_en = 1'b0;

        // saturating 2-digit instance: load 95, count up six times
        b_ld = 1'b1; b_ldata = 8'h95; cyc();
        b_ld = 1'b0; b_en = 1'b1; b_up = 1'b1; b_trig = 2'b01;
        repeat (4) cyc();
        chk("plan.sat_99", {24'h0, b_out}, 32'h99);
        cyc();
        chk("plan.sat_ovf1", {23'h0, b_ovf, b_out}, 32'h199);
        cyc();
        chk("plan.sat_ovf2", {23'h0, b_ovf, b_out}, 32'h199);
        b_up = 1'b0; b_trig = 2'b10; b_ld = 1'b1; b_ldata = 8'h05; cyc();
        b_ld = 1'b0; cyc();
        chk("plan.sat_zero", {23'h0, b_unf, b_out}, 32'h100);

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_ld    = ($urandom_range(0, 9) == 0);
            a_ldata = 16'($urandom);
            a_en    = ($urandom_range(0, 3) != 0);
            a_up    = 1'($urandom);
            a_trig  = 4'($urandom);
            b_ld    = ($urandom_range(0, 9) == 0);
            b_ldata = 8'($urandom);
            b_en    = ($urandom_range(0, 3) != 0);
            b_up    = 1'($urandom);
            b_trig  = 2'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised N-digit packed-BCD up/down counter; successor to the fixed four-digit BCD counter.
Each cycle, per-digit trigger bits form a BCD addend (digit k contributes 10^k), which is added to or subtracted from the count with full decimal carry/borrow ripple.
Adds synchronous load, count enable, a selectable wrap/saturate mode and overflow/underflow/load-error flags.
Sits between the button/timer front end and the seven-segment display driver on Basys3.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
WRAP, 1, 1 = modulo-10^DIGITS wrap; 0 = saturate at 0 and at 10^DIGITS-1

Ports:
Clk  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
Enable  input  1  count enable; Trigger is ignored when low
Up  input  1  1 = add, 0 = subtract
Trigger  input  DIGITS  bit k set = add/subtract 10^k this cycle
Load  input  1  synchronous load strobe
LoadData  input  4*DIGITS  packed BCD load value, digit 0 in [3:0]
DataOut  output  4*DIGITS  packed BCD count, digit 0 in [3:0]
Overflow  output  1  one-cycle pulse: add crossed 10^DIGITS-1
Underflow  output  1  one-cycle pulse: subtract crossed below 0
LoadError  output  1  one-cycle pulse: LoadData held a nibble > 9

Behaviour:
- Reset asserted (asynchronous, any time including mid-count): DataOut=0, Overflow=0, Underflow=0, LoadError=0 immediately; held while Reset is high.
- All outputs are registered. Inputs are sampled on rising Clk; the result is visible after that edge (1-cycle latency). No combinational input-to-output path.
- Priority per edge: Load > (Enable & |Trigger) > hold.
- Load: each nibble of LoadData <= 9 is copied to the digit; each nibble > 9 is loaded as 0. LoadError=1 for one cycle if any nibble was invalid. Overflow and Underflow are 0 on a load cycle.
- Count cycle (Enable=1, Load=0): addend A has digit k = Trigger[k] (0 or 1).
- Up=1: ripple BCD add from digit 0: s = d + a + c; if s > 9 then digit = s-10 and carry 1; otherwise digit = s and carry 0.
- Up=0: ripple BCD subtract: s = d - a - b; if s < 0 then digit = s+10 and borrow 1; otherwise digit = s and borrow 0.
- Overflow when the final carry out of the top digit is 1. Underflow when the final borrow out is 1.
- WRAP=1: keep the modulo result; the flag pulses for one cycle.
- WRAP=0: on overflow DataOut becomes all 9s; on underflow DataOut becomes 0. The flag still pulses.
- Enable=0, or Trigger=0: count holds and all flags are 0.
- Flags are cleared on every non-event cycle, so back-to-back events produce back-to-back pulses.
- DataOut never contains a nibble > 9 in any state.

Test Plan:
- Reset, then Up=1, Enable=1, Trigger=4'b1111 for 10 cycles (DIGITS=4, WRAP=1) -> DataOut 0x1111, 0x2222, ..., 0x9999, then 0x1110 with Overflow=1 on that cycle only.
- Load LoadData=0x0005, then Up=0, Trigger=4'b0010 for one cycle -> WRAP=1: DataOut=0x9995, Underflow pulse. WRAP=0: DataOut=0x0000, Underflow pulse.
- Load 0x0999, then Up=1, Trigger=4'b0001 -> DataOut=0x1000 (3-digit carry ripple), no flag. Then Up=0, Trigger=4'b0001 -> DataOut=0x0999.
- Load 0x12F4 -> DataOut=0x1204, LoadError=1 for one cycle. Load and Trigger=4'b1111 in the same cycle -> the load wins, no count.
- Enable=0 with Trigger=4'b1111 for 5 cycles -> DataOut unchanged, no flags. Assert Reset asynchronously mid-cycle while counting -> DataOut=0 before the next Clk edge; counting resumes from 0x1111 on the first edge after Reset is released.
- DIGITS=2, WRAP=0: Load 0x95, then Up=1, Trigger=2'b01 for 6 cycles -> 0x96, 0x97, 0x98, 0x99, 0x99 (Overflow pulse), 0x99 (Overflow pulse).
